dc_ipu_scale_sequencer: RTL

- Frame-level scan sequencer for the cubic scaling filter.
- On `start`, walks every output pixel in raster order and computes, for each one:
  - the integer source texel position (top-left of the 4x4 neighbourhood anchor), via fixed-point DDA accumulators;
  - the fractional filter coefficients.
- Emits one valid/ready request per output pixel. Requests feed the texel fetch stage and then the filter's `coeff_x`/`coeff_y` inputs.
- Owns frame start/done signalling for the scaler pipeline.

---
 rtl/dc_ipu_scale_sequencer.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/dc_ipu_scale_sequencer.sv
// Frame-level raster scan sequencer for the cubic scaler: walks every output
// pixel, tracks fixed-point source positions with saturating DDA accumulators
// and emits one clamped {src position, coefficient} request per output pixel.
module dc_ipu_scale_sequencer #(
  parameter int unsigned COORD_WIDTH      = 12,
  parameter int unsigned STEP_FRACT_WIDTH = 16,
  parameter int unsigned COEFF_WIDTH      = 6
) (
  input  logic                                  clk,
  input  logic                                  nreset,
  input  logic                                  clr,
  input  logic                                  start,
  input  logic [COORD_WIDTH-1:0]                cfg_out_width,
  input  logic [COORD_WIDTH-1:0]                cfg_out_height,
  input  logic [COORD_WIDTH-1:0]                cfg_src_width,
  input  logic [COORD_WIDTH-1:0]                cfg_src_height,
  input  logic [COORD_WIDTH+STEP_FRACT_WIDTH-1:0] cfg_step_x,
  input  logic [COORD_WIDTH+STEP_FRACT_WIDTH-1:0] cfg_step_y,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [COORD_WIDTH-1:0]                out_src_x,
  output logic [COORD_WIDTH-1:0]                out_src_y,
  output logic [COEFF_WIDTH-1:0]                out_coeff_x,
  output logic [COEFF_WIDTH-1:0]                out_coeff_y,
  output logic                                  out_eol,
  output logic                                  out_eof
);

  localparam int unsigned STEP_WIDTH = COORD_WIDTH + STEP_FRACT_WIDTH;
  localparam int unsigned ACC_WIDTH  = STEP_WIDTH + 1;
  localparam int unsigned SUM_WIDTH  = ACC_WIDTH + 1;
  localparam int unsigned INT_WIDTH  = ACC_WIDTH - STEP_FRACT_WIDTH;
  localparam int unsigned PIX_WIDTH  = COORD_WIDTH + COEFF_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [COORD_WIDTH-1:0] out_w_q, out_w_d, out_h_q, out_h_d;
  logic [COORD_WIDTH-1:0] src_w_q, src_w_d, src_h_q, src_h_d;
  logic [STEP_WIDTH-1:0]  step_x_q, step_x_d, step_y_q, step_y_d;
  logic [COORD_WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic [ACC_WIDTH-1:0]   acc_x_q, acc_x_d, acc_y_q, acc_y_d;

  logic                   busy_q, busy_d, done_q, done_d, valid_q, valid_d;
  logic [COORD_WIDTH-1:0] src_x_q, src_x_d, src_y_q, src_y_d;
  logic [COEFF_WIDTH-1:0] coeff_x_q, coeff_x_d, coeff_y_q, coeff_y_d;
  logic                   eol_q, eol_d, eof_q, eof_d;

  logic hs_c, last_x_c, last_y_c, accept_c, zero_size_c, run_d;

  // Accumulator add that sticks at all-ones instead of wrapping.
  function automatic logic [ACC_WIDTH-1:0] sat_add(input logic [ACC_WIDTH-1:0]  acc,
                                                   input logic [STEP_WIDTH-1:0] step);
    logic [SUM_WIDTH-1:0] sum;
    sum = SUM_WIDTH'(acc) + SUM_WIDTH'(step);
    return sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
  endfunction

  // Integer texel position clamped to the source extent, plus truncated coefficient.
  function automatic logic [PIX_WIDTH-1:0] clamp_pos(input logic [ACC_WIDTH-1:0]   acc,
                                                     input logic [COORD_WIDTH-1:0] lim);
    logic [INT_WIDTH-1:0] ipart;
    ipart = acc[ACC_WIDTH-1:STEP_FRACT_WIDTH];
    if (ipart >= INT_WIDTH'(lim)) begin
      return {lim - COORD_WIDTH'(1), COEFF_WIDTH'(0)};
    end
    return {ipart[COORD_WIDTH-1:0], acc[STEP_FRACT_WIDTH-1 -: COEFF_WIDTH]};
  endfunction

  assign hs_c        = valid_q & out_ready;
  assign last_x_c    = (x_q == out_w_q - COORD_WIDTH'(1));
  assign last_y_c    = (y_q == out_h_q - COORD_WIDTH'(1));
  assign accept_c    = (state_q == ST_IDLE) & start;
  assign zero_size_c = (cfg_out_width == '0) | (cfg_out_height == '0);

  // State register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; clr overrides everything.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = zero_size_c ? ST_FIN : ST_RUN;
      ST_RUN:  if (hs_c && last_x_c && last_y_c) state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (clr) state_d = ST_IDLE;
  end

  // Config latch, raster counters and DDA accumulators.
  always_comb begin
    out_w_d  = out_w_q;
    out_h_d  = out_h_q;
    src_w_d  = src_w_q;
    src_h_d  = src_h_q;
    step_x_d = step_x_q;
    step_y_d = step_y_q;
    x_d      = x_q;
    y_d      = y_q;
    acc_x_d  = acc_x_q;
    acc_y_d  = acc_y_q;
    if (clr) begin
      x_d     = '0;
      y_d     = '0;
      acc_x_d = '0;
      acc_y_d = '0;
    end else if (accept_c) begin
      out_w_d  = cfg_out_width;
      out_h_d  = cfg_out_height;
      // A zero source extent behaves as a single texel.
      src_w_d  = (cfg_src_width  == '0) ? COORD_WIDTH'(1) : cfg_src_width;
      src_h_d  = (cfg_src_height == '0) ? COORD_WIDTH'(1) : cfg_src_height;
      step_x_d = cfg_step_x;
      step_y_d = cfg_step_y;
      x_d      = '0;
      y_d      = '0;
      acc_x_d  = '0;
      acc_y_d  = '0;
    end else if ((state_q == ST_RUN) && hs_c) begin
      if (last_x_c) begin
        x_d     = '0;
        acc_x_d = '0;
        if (last_y_c) begin
          y_d     = '0;
          acc_y_d = '0;
        end else begin
          y_d     = y_q + COORD_WIDTH'(1);
          acc_y_d = sat_add(acc_y_q, step_y_q);
        end
      end else begin
        x_d     = x_q + COORD_WIDTH'(1);
        acc_x_d = sat_add(acc_x_q, step_x_q);
      end
    end
  end

  // Output values for the next cycle, derived from the next datapath state.
  always_comb begin
    run_d  = (state_d == ST_RUN);
    busy_d = run_d;
    valid_d = run_d;
    done_d = (state_d == ST_FIN);
    {src_x_d, coeff_x_d} = run_d ? clamp_pos(acc_x_d, src_w_d) : '0;
    {src_y_d, coeff_y_d} = run_d ? clamp_pos(acc_y_d, src_h_d) : '0;
    eol_d = run_d && (x_d == out_w_d - COORD_WIDTH'(1));
    eof_d = eol_d && (y_d == out_h_d - COORD_WIDTH'(1));
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      out_w_q   <= '0;
      out_h_q   <= '0;
      src_w_q   <= '0;
      src_h_q   <= '0;
      step_x_q  <= '0;
      step_y_q  <= '0;
      x_q       <= '0;
      y_q       <= '0;
      acc_x_q   <= '0;
      acc_y_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      src_x_q   <= '0;
      src_y_q   <= '0;
      coeff_x_q <= '0;
      coeff_y_q <= '0;
      eol_q     <= 1'b0;
      eof_q     <= 1'b0;
    end else begin
      out_w_q   <= out_w_d;
      out_h_q   <= out_h_d;
      src_w_q   <= src_w_d;
      src_h_q   <= src_h_d;
      step_x_q  <= step_x_d;
      step_y_q  <= step_y_d;
      x_q       <= x_d;
      y_q       <= y_d;
      acc_x_q   <= acc_x_d;
      acc_y_q   <= acc_y_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
      src_x_q   <= src_x_d;
      src_y_q   <= src_y_d;
      coeff_x_q <= coeff_x_d;
      coeff_y_q <= coeff_y_d;
      eol_q     <= eol_d;
      eof_q     <= eof_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign out_valid   = valid_q;
  assign out_src_x   = src_x_q;
  assign out_src_y   = src_y_q;
  assign out_coeff_x = coeff_x_q;
  assign out_coeff_y = coeff_y_q;
  assign out_eol     = eol_q;
  assign out_eof     = eof_q;

endmodule
